ct_spsram_arb_ctrl: RTL
=======================

Name: ct_spsram_arb_ctrl

Overview:
- Two-requester arbiter and sequencer for one 8192x32 single-port SRAM (FPGA RAM model; active-low CEN/GWEN/per-bit WEN; synchronous read, data valid the cycle after the access).
- Grants at most one access per cycle using round-robin.
- Converts per-requester valid/ready requests with byte strobes into SRAM pin controls.
- Routes read data back to the requester that issued the read.
- Optionally clears the array after reset before accepting traffic.

Parameters:
ADDR_WIDTH, 13, SRAM word address width
DATA_WIDTH, 32, SRAM data width, a multiple of 8
DEPTH, 8192, number of words, equal to 2**ADDR_WIDTH

Ports:
forever_cpuclk  input  1  clock; all state on rising edge
cpurst_b  input  1  asynchronous active-low reset
req0_vld  input  1  requester 0 request valid
req0_wr  input  1  1 = write, 0 = read
req0_addr  input  ADDR_WIDTH  word address
req0_be  input  DATA_WIDTH/8  byte enables for writes, active-high
req0_wdata  input  DATA_WIDTH  write data
req0_rdy  output  1  request 0 accepted this cycle
req0_rvld  output  1  read data valid for requester 0
req1_vld, req1_wr, req1_addr, req1_be, req1_wdata, req1_rdy, req1_rvld: same as requester 0
rdata  output  DATA_WIDTH  read data, shared by both requesters
init_done  output  1  high once arbitration is enabled
sram_a  output  ADDR_WIDTH  SRAM address
sram_cen  output  1  SRAM chip enable, active-low
sram_gwen  output  1  SRAM global write enable, active-low
sram_wen  output  DATA_WIDTH  SRAM per-bit write enable, active-low
sram_d  output  DATA_WIDTH  SRAM write data
sram_q  input  DATA_WIDTH  SRAM read data

Behaviour:
- Reset is asynchronous and active-low on cpurst_b; one clock, forever_cpuclk.
- States: INIT and ARB.
- Reset values:
  - state = INIT if the macro is defined, else ARB.
  - init counter = 0; round-robin pointer = 0, meaning requester 0 has priority.
  - rvld pipeline regs = 0; init_done = 0 with the macro, 1 without.
  - sram_cen = 1, sram_gwen = 1, sram_wen = all ones; all rdy = 0.
- ARB, requester selection:
  - Only requester 0 valid: grant 0. Only requester 1 valid: grant 1.
  - Both valid: grant the pointer's requester, then the pointer moves to the other requester.
  - Grant with only one requester valid: the pointer moves to the non-granted requester.
  - No grant: the pointer holds.
- ARB, outputs:
  - reqN_rdy is combinational: state == ARB && granted N. The handshake is vld && rdy in the same cycle.
  - Granted cycle: sram_cen = 0; sram_a = granted addr.
  - Granted write: sram_gwen = 0; sram_wen byte k = all eight bits equal to ~be[k]; sram_d = wdata.
  - Granted read: sram_gwen = 1; sram_wen = all ones.
  - No grant: sram_cen = 1 and sram_gwen = 1; sram_a and sram_d hold their last values (registered mux select).
  - A write with be == 0 is still accepted and consumes the slot.
- Read latency:
  - reqN_rvld pulses exactly one cycle after the read handshake.
  - rdata = sram_q, combinational passthrough, valid only while a rvld is high.
  - Back-to-back reads from alternating requesters are supported at full throughput.
  - req0_rvld and req1_rvld are never both high.
- Writes produce no response. A read after a write to the same address in the next cycle returns the new data.
- INIT, when enabled:
  - Every cycle: sram_cen = 0, sram_gwen = 0, sram_wen = 0, sram_d = 0, sram_a = counter; counter increments.
  - At counter == DEPTH-1, that write completes and state goes to ARB with init_done = 1 on the next cycle.
  - Both rdy stay 0 for DEPTH cycles; valid requests are held and not dropped.
- Reset mid-operation: any pending rvld is cancelled; an INIT sweep restarts from address 0.
- A requester may change addr/wdata while vld is high and rdy is low; the value sampled is the one present in the handshake cycle.

Optional Feature:
- Macro: SPSRAM_INIT_EN.
- Defined: INIT state present; memory is zeroed in DEPTH cycles after reset; init_done rises at cycle DEPTH.
- Undefined: no INIT state or counter; ARB from reset; init_done tied to 1; first grant possible in the first cycle after reset deassertion.

Test Plan:
- Reset with SPSRAM_INIT_EN; hold req0 read addr 0x0005 → rdy 0 for 8192 cycles, then init_done = 1, handshake, req0_rvld next cycle, rdata = 0x00000000.
- req0 write 0x1ABC = 0xDEADBEEF with be = 4'b1111, then write be = 4'b0010 data 0x00005500, then read → rdata = 0xDEAD55EF one cycle after the read grant.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; rvld follows one cycle later with the matching requester.
- req1 only for 3 cycles, then both valid → the first contested grant goes to requester 0.
- Assert cpurst_b low the cycle after a req1 read handshake → req1_rvld never pulses; state returns to INIT, counter = 0.
- Without the macro: req0 read in the first cycle after reset → rdy = 1 immediately; sram_cen = 0, sram_gwen = 1, sram_wen = 0xFFFFFFFF.

Source files
------------

// File: rtl/ct_spsram_arb_ctrl.sv
// Two-requester round-robin arbiter and pin sequencer for one single-port SRAM.
// Optional post-reset array clear is enabled by defining SPSRAM_INIT_EN.
module ct_spsram_arb_ctrl #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    req0_vld,
    input  logic                    req0_wr,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH/8-1:0] req0_be,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    output logic                    req0_rdy,
    output logic                    req0_rvld,
    input  logic                    req1_vld,
    input  logic                    req1_wr,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH/8-1:0] req1_be,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    output logic                    req1_rdy,
    output logic                    req1_rvld,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    init_done,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);
    localparam int BE_W = DATA_WIDTH / 8;

    if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end

    function automatic logic [DATA_WIDTH-1:0] be_to_wen(input logic [BE_W-1:0] be);
        logic [DATA_WIDTH-1:0] wen;
        wen = '1;
        for (int k = 0; k < BE_W; k++) begin
            wen[k*8 +: 8] = {8{~be[k]}};
        end
        return wen;
    endfunction

    logic                  ptr_q, ptr_d;
    logic                  rvld0_q, rvld0_d, rvld1_q, rvld1_d;
    logic [ADDR_WIDTH-1:0] last_a_q, last_a_d;
    logic [DATA_WIDTH-1:0] last_d_q, last_d_d;
    logic                  arb_en;

`ifdef SPSRAM_INIT_EN
    typedef enum logic {ST_INIT, ST_ARB} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;

    assign arb_en    = (state_q == ST_ARB);
    assign init_done = init_done_q;
`else
    assign arb_en    = 1'b1;
    assign init_done = 1'b1;
`endif

    // Gating with cpurst_b keeps the pins idle while reset is held.
    logic gnt_vld, gnt_sel;
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (cpurst_b && arb_en) begin
            if (req0_vld && req1_vld) begin
                gnt_vld = 1'b1;
                gnt_sel = ptr_q;
            end else if (req0_vld) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b0;
            end else if (req1_vld) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BE_W-1:0]       sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign sel_wr    = gnt_sel ? req1_wr    : req0_wr;
    assign sel_addr  = gnt_sel ? req1_addr  : req0_addr;
    assign sel_be    = gnt_sel ? req1_be    : req0_be;
    assign sel_wdata = gnt_sel ? req1_wdata : req0_wdata;

    always_comb begin
        ptr_d     = ptr_q;
        rvld0_d   = 1'b0;
        rvld1_d   = 1'b0;
        last_a_d  = last_a_q;
        last_d_d  = last_d_q;
        req0_rdy  = 1'b0;
        req1_rdy  = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = last_a_q;
        sram_d    = last_d_q;
`ifdef SPSRAM_INIT_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (cpurst_b && state_q == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            sram_d    = '0;
            last_a_d  = cnt_q;
            last_d_d  = '0;
            cnt_d     = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d     = ST_ARB;
                init_done_d = 1'b1;
            end
        end
`endif
        if (gnt_vld) begin
            req0_rdy = ~gnt_sel;
            req1_rdy = gnt_sel;
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            last_a_d = sel_addr;
            ptr_d    = ~gnt_sel;
            if (sel_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = be_to_wen(sel_be);
                sram_d    = sel_wdata;
                last_d_d  = sel_wdata;
            end else begin
                // SRAM returns data next cycle; tag it with the issuing requester.
                rvld0_d = ~gnt_sel;
                rvld1_d = gnt_sel;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ptr_q       <= 1'b0;
            rvld0_q     <= 1'b0;
            rvld1_q     <= 1'b0;
            last_a_q    <= '0;
            last_d_q    <= '0;
`ifdef SPSRAM_INIT_EN
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            rvld0_q     <= rvld0_d;
            rvld1_q     <= rvld1_d;
            last_a_q    <= last_a_d;
            last_d_q    <= last_d_d;
`ifdef SPSRAM_INIT_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
`endif
        end
    end

    assign req0_rvld = rvld0_q;
    assign req1_rvld = rvld1_q;
    assign rdata     = sram_q;

endmodule
